// File: rtl/lct_hit_injector_if.sv
// Request/response bus of the LCT hit injector.
// The stagger field exists only when LCT_INJ_STAGGER_EN is defined.
// Handshake: start and abort are single-cycle request pulses with no ready
// (start is accepted only while idle; abort wins over start); busy is high
// while a sequence runs, and done pulses for one cycle when it ends.
interface lct_hit_injector_if #(
   parameter int NWIRE  = 64,
   parameter int MAXREP = 255
);
   localparam int KW = $clog2(NWIRE);
   localparam int RW = $clog2(MAXREP + 1);

   logic             start;
   logic             abort;
   logic [KW-1:0]    key;
   logic             accel;
   logic [2:0]       nlayers;
   logic [3:0]       delay;
   logic [2:0]       width;
   logic [3:0]       gap;
   logic [RW-1:0]    nrep;
`ifdef LCT_INJ_STAGGER_EN
   logic [1:0]       stagger;
`endif
   logic [NWIRE-1:0] ly0p, ly1p, ly2p, ly3p, ly4p, ly5p;
   logic             busy;
   logic             done;
   logic             exp_v;
   logic [KW:0]      exp_key;
   logic [1:0]       exp_q;
   logic             exp_fa;

   modport master (
`ifdef LCT_INJ_STAGGER_EN
      output stagger,
`endif
      output start, abort, key, accel, nlayers, delay, width, gap, nrep,
      input  ly0p, ly1p, ly2p, ly3p, ly4p, ly5p,
      input  busy, done, exp_v, exp_key, exp_q, exp_fa
   );

   modport slave (
`ifdef LCT_INJ_STAGGER_EN
      input  stagger,
`endif
      input  start, abort, key, accel, nlayers, delay, width, gap, nrep,
      output ly0p, ly1p, ly2p, ly3p, ly4p, ly5p,
      output busy, done, exp_v, exp_key, exp_q, exp_fa
   );
endinterface

// File: rtl/lct_hit_injector.sv
// LCT hit injector: drives synthetic per-layer hits for a requested track
// and publishes the LCT the wire-group trigger should report for it.
// Optional per-layer staggering of the fire window: LCT_INJ_STAGGER_EN.
module lct_hit_injector #(
   parameter int NWIRE  = 64,
   parameter int MAXREP = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   lct_hit_injector_if.slave inj,
   output logic [2:0]        dbg_state_o
);
   localparam int KW = $clog2(NWIRE);
   localparam int RW = $clog2(MAXREP + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DELAY = 3'd1;
   localparam logic [2:0] S_FIRE  = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [RW-1:0]    rep_q, rep_d;
   logic [KW-1:0]    key_q, key_d;
   logic             accel_q, accel_d;
   logic [2:0]       nl_q, nl_d;
   logic [3:0]       dly_q, dly_d;
   logic [2:0]       wid_q, wid_d;
   logic [3:0]       gap_q, gap_d;
   logic [4:0]       fire_max;
   logic             fire_d;

   logic [NWIRE-1:0] pat [6];
   logic [5:0]       placed_mask;
   logic [2:0]       placed;
   logic [2:0]       nl_eff;
   logic [5:0]       layer_on;
   int               widx_c;

   logic [NWIRE-1:0] ly_q [6];
   logic             busy_q, done_q, exp_v_q, exp_fa_q;
   logic [KW:0]      exp_key_q;
   logic [1:0]       exp_q_q;

`ifdef LCT_INJ_STAGGER_EN
   logic [1:0]       stg_q, stg_d;
   logic [4:0]       stg_start;
   // FIRE stretches so the last layer still gets its full width
   assign fire_max = {2'b00, wid_q} + 5'(stg_q) * 5'd5;
`else
   assign fire_max = {2'b00, wid_q};
`endif

   // Sequencer: capture on start, walk DELAY/FIRE/GAP, abort wins
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rep_d   = rep_q;
      key_d   = key_q;
      accel_d = accel_q;
      nl_d    = nl_q;
      dly_d   = dly_q;
      wid_d   = wid_q;
      gap_d   = gap_q;
`ifdef LCT_INJ_STAGGER_EN
      stg_d   = stg_q;
`endif
      case (state_q)
         S_IDLE: if (inj.start && !inj.abort) begin
            key_d   = inj.key;
            accel_d = inj.accel;
            nl_d    = inj.nlayers;
            dly_d   = inj.delay;
            wid_d   = inj.width;
            gap_d   = inj.gap;
            rep_d   = inj.nrep;
`ifdef LCT_INJ_STAGGER_EN
            stg_d   = inj.stagger;
`endif
            cnt_d   = '0;
            state_d = (inj.delay != 4'd0) ? S_DELAY : S_FIRE;
         end
         S_DELAY: begin
            if (cnt_q == {1'b0, dly_q} - 5'd1) begin
               cnt_d   = '0;
               state_d = S_FIRE;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_FIRE: begin
            if (cnt_q == fire_max) begin
               cnt_d = '0;
               if (rep_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  rep_d   = rep_q - RW'(1);
                  state_d = (gap_q != 4'd0) ? S_GAP : S_FIRE;
               end
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_GAP: begin
            if (cnt_q == {1'b0, gap_q} - 5'd1) begin
               cnt_d   = '0;
               state_d = S_FIRE;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A sequence already finishing in DONE has pulsed done; just go idle
      if (inj.abort && state_q != S_IDLE) begin
         state_d = (state_q == S_DONE) ? S_IDLE : S_DONE;
         cnt_d   = '0;
      end
   end

   assign fire_d = (state_d == S_FIRE);

   // Hit pattern from the (possibly just captured) track; edge hits are dropped
   always_comb begin
      nl_eff = (nl_d < 3'd3) ? 3'd3 : ((nl_d == 3'd7) ? 3'd6 : nl_d);
      widx_c = 0;
      for (int n = 0; n < 6; n++) begin
         widx_c = int'(key_d);
         if (!accel_d) begin
            if (n < 2)       widx_c = widx_c - 1;
            else if (n >= 4) widx_c = widx_c + 1;
         end
         pat[n]         = '0;
         placed_mask[n] = 1'b0;
         if ((3'(n) < nl_eff || n == 2) && widx_c >= 0 && widx_c < NWIRE) begin
            pat[n][widx_c[KW-1:0]] = 1'b1;
            placed_mask[n]         = 1'b1;
         end
      end
      placed = 3'($countones(placed_mask));
   end

`ifdef LCT_INJ_STAGGER_EN
   // Layer n is live for width+1 cycles starting n*stagger into FIRE
   always_comb begin
      stg_start = '0;
      for (int n = 0; n < 6; n++) begin
         stg_start   = 5'(n) * {3'b000, stg_d};
         layer_on[n] = (cnt_d >= stg_start) && (cnt_d <= stg_start + {2'b00, wid_d});
      end
   end
`else
   assign layer_on = '1;
`endif

   // Sequencer and captured request registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rep_q   <= '0;
         key_q   <= '0;
         accel_q <= 1'b0;
         nl_q    <= '0;
         dly_q   <= '0;
         wid_q   <= '0;
         gap_q   <= '0;
`ifdef LCT_INJ_STAGGER_EN
         stg_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rep_q   <= rep_d;
         key_q   <= key_d;
         accel_q <= accel_d;
         nl_q    <= nl_d;
         dly_q   <= dly_d;
         wid_q   <= wid_d;
         gap_q   <= gap_d;
`ifdef LCT_INJ_STAGGER_EN
         stg_q   <= stg_d;
`endif
      end
   end

   // Registered outputs, derived from the next state so they align with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 6; n++) ly_q[n] <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         exp_v_q   <= 1'b0;
         exp_key_q <= '0;
         exp_q_q   <= '0;
         exp_fa_q  <= 1'b0;
      end else begin
         for (int n = 0; n < 6; n++) ly_q[n] <= (fire_d && layer_on[n]) ? pat[n] : '0;
         busy_q    <= (state_d == S_DELAY) || (state_d == S_FIRE) || (state_d == S_GAP);
         done_q    <= (state_d == S_DONE);
         exp_v_q   <= fire_d && (placed >= 3'd3) && (&(layer_on | ~placed_mask));
         exp_key_q <= fire_d ? {1'b0, key_d} : '0;
         exp_q_q   <= (fire_d && placed >= 3'd3) ? 2'(placed - 3'd3) : 2'd0;
         exp_fa_q  <= fire_d && accel_d;
      end
   end

   assign inj.ly0p    = ly_q[0];
   assign inj.ly1p    = ly_q[1];
   assign inj.ly2p    = ly_q[2];
   assign inj.ly3p    = ly_q[3];
   assign inj.ly4p    = ly_q[4];
   assign inj.ly5p    = ly_q[5];
   assign inj.busy    = busy_q;
   assign inj.done    = done_q;
   assign inj.exp_v   = exp_v_q;
   assign inj.exp_key = exp_key_q;
   assign inj.exp_q   = exp_q_q;
   assign inj.exp_fa  = exp_fa_q;
   assign dbg_state_o = state_q;
endmodule

// File: tb/tb_lct_hit_injector.sv
// Testbench for lct_hit_injector: per-cycle expected-output trace built from
// the request (delay, fire windows, gaps, done, idle) and compared each cycle.
module tb_lct_hit_injector;
   localparam int W = 6 * 64 + 13;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   lct_hit_injector_if bus ();
   logic [2:0] dbg_state;

   lct_hit_injector dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .inj         (bus),
      .dbg_state_o (dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q [$];

   int r_key, r_accel, r_nl, r_delay, r_width, r_gap, r_nrep;
   int coll_off [6] = '{-1, -1, 0, 0, 1, 1};

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   function automatic logic [W-1:0] dut_vec();
      return {bus.ly5p, bus.ly4p, bus.ly3p, bus.ly2p, bus.ly1p, bus.ly0p,
              bus.busy, bus.done, bus.exp_v, bus.exp_key, bus.exp_q, bus.exp_fa};
   endfunction

   // ---------------- reference model ----------------
   // Expected outputs during one fire cycle of the current request
   function automatic logic [W-1:0] fire_vec();
      logic [383:0] ly;
      int placed, nl_eff, w;
      ly = '0;
      placed = 0;
      nl_eff = (r_nl < 3) ? 3 : ((r_nl > 6) ? 6 : r_nl);
      for (int l = 0; l < 6; l++) begin
         if (l < nl_eff || l == 2) begin
            w = r_key + ((r_accel != 0) ? 0 : coll_off[l]);
            if (w >= 0 && w < 64) begin
               ly[l * 64 + w] = 1'b1;
               placed++;
            end
         end
      end
      return {ly, 1'b1, 1'b0, (placed >= 3) ? 1'b1 : 1'b0, 7'(r_key),
              (placed >= 3) ? 2'(placed - 3) : 2'd0, 1'(r_accel)};
   endfunction

   // Trace for cycles 1.. after the start cycle; abort_at>0 cuts it short
   task automatic build_trace(input int abort_at);
      logic [W-1:0] busy_v, done_v, fv;
      busy_v = '0; busy_v[12] = 1'b1;
      done_v = '0; done_v[11] = 1'b1;
      fv = fire_vec();
      exp_q.delete();
      for (int d = 0; d < r_delay; d++) exp_q.push_back(busy_v);
      for (int r = 0; r <= r_nrep; r++) begin
         for (int c = 0; c <= r_width; c++) exp_q.push_back(fv);
         if (r < r_nrep)
            for (int g = 0; g < r_gap; g++) exp_q.push_back(busy_v);
      end
      if (abort_at > 0 && abort_at <= exp_q.size())
         while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      exp_q.push_back(done_v);
      exp_q.push_back('0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_req(input int k, input int a, input int nl, input int d,
                          input int w, input int g, input int n);
      r_key = k; r_accel = a; r_nl = nl; r_delay = d; r_width = w; r_gap = g; r_nrep = n;
   endtask

   function automatic int busy_len();
      return r_delay + (r_nrep + 1) * (r_width + 1) + r_nrep * r_gap;
   endfunction

   task automatic scramble();
      bus.key     = 6'($urandom);
      bus.accel   = 1'($urandom);
      bus.nlayers = 3'($urandom);
      bus.delay   = 4'($urandom);
      bus.width   = 3'($urandom);
      bus.gap     = 4'($urandom);
      bus.nrep    = 8'($urandom);
   endtask

   task automatic drive_start();
      bus.start   = 1'b1;
      bus.abort   = 1'b0;
      bus.key     = 6'(r_key);
      bus.accel   = 1'(r_accel);
      bus.nlayers = 3'(r_nl);
      bus.delay   = 4'(r_delay);
      bus.width   = 3'(r_width);
      bus.gap     = 4'(r_gap);
      bus.nrep    = 8'(r_nrep);
   endtask

   // Start a sequence and compare every cycle until the idle cycle after done.
   // Inputs are scrambled during the run; start is also pulsed in the done cycle.
   task automatic run_seq(input int abort_at, input int extra_start_at);
      logic [W-1:0] want, got;
      int n;
      build_trace(abort_at);
      n = exp_q.size();
      @(posedge clk); #1;
      drive_start();
      for (int t = 1; t <= n; t++) begin
         @(posedge clk); #1;
         scramble();
         bus.start = ((t == extra_start_at) && (t < n - 1)) || (t == n - 1);
         bus.abort = (t == abort_at);
         @(negedge clk);
         want = exp_q.pop_front();
         got  = dut_vec();
         check("ly", W'(got[W-1:13]), W'(want[W-1:13]));
         check("ctl", W'(got[12:10]), W'(want[12:10]));
         if (want[10]) check("lct", W'(got[9:0]), W'(want[9:0]));
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      set_req(0, 0, 0, 0, 0, 0, 0);
      scramble();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset", dut_vec(), '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle", dut_vec(), '0);

      // single-cycle accelerator track, all layers
      set_req(30, 1, 6, 0, 0, 0, 0);  run_seq(0, 0);
      // collision track, four layers, three-cycle pulse
      set_req(10, 0, 4, 0, 2, 0, 0);  run_seq(0, 0);
      // boundary wires
      set_req(0, 0, 6, 0, 0, 0, 0);   run_seq(0, 0);
      set_req(63, 0, 6, 0, 1, 0, 0);  run_seq(0, 0);
      set_req(0, 0, 3, 0, 0, 0, 0);   run_seq(0, 0);
      set_req(63, 0, 1, 1, 0, 0, 0);  run_seq(0, 0);
      set_req(40, 1, 7, 0, 0, 0, 1);  run_seq(0, 0);
      // delay, gap and repeats; start mid-sequence is ignored
      set_req(17, 0, 5, 5, 1, 3, 2);  run_seq(0, 10);
      // back-to-back repeats with no gap
      set_req(33, 1, 3, 2, 0, 0, 3);  run_seq(0, 0);
      // long sequence aborted at cycle 40, then a fresh start right after
      set_req(50, 0, 6, 3, 4, 2, 255); run_seq(40, 0);
      set_req(5, 1, 5, 0, 1, 0, 0);   run_seq(0, 0);

      // abort while idle: no done pulse
      @(posedge clk); #1;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      @(negedge clk);
      check("idle_abort", dut_vec(), '0);

      // randomized requests, some aborted
      for (int i = 0; i < 24; i++) begin
         int ab, ex;
         set_req($urandom_range(0, 63), $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15),
                 $urandom_range(0, 3));
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, busy_len()) : 0;
         ex = $urandom_range(1, busy_len());
         run_seq(ab, ex);
      end

      // asynchronous reset in the middle of FIRE
      set_req(20, 0, 5, 2, 7, 0, 3);
      @(posedge clk); #1;
      drive_start();
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("fire_pre", W'(dut_vec() >> 13), W'(fire_vec() >> 13));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst", dut_vec(), '0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst_hold", dut_vec(), '0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst", dut_vec(), '0);
      set_req(62, 0, 6, 1, 2, 1, 1);  run_seq(0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
